// File: rtl/execute_branch_resolve.sv
// Execute-stage branch resolution: registers the branch unit result, compares
// it with the fetch prediction, and sequences flush / interrupt-branch / halt
// handshakes. Upstream is stalled while any request is outstanding.
// Optional statistics counters: define EXECUTE_BRANCH_RESOLVE_STAT_EN.
module execute_branch_resolve (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
`ifdef EXECUTE_BRANCH_RESOLVE_STAT_EN
  output logic [31:0] oSTAT_BRANCH_COUNT,
  output logic [31:0] oSTAT_MISS_COUNT,
`endif
  input  logic        iVALID,
  output logic        oBUSY,
  input  logic [31:0] iPC,
  input  logic [31:0] iBRANCH_ADDR,
  input  logic        iJUMP_VALID,
  input  logic        iNOT_JUMP_VALID,
  input  logic        iIB_VALID,
  input  logic        iIDTS_VALID,
  input  logic        iHALT_VALID,
  input  logic        iPREDICT_TAKEN,
  input  logic [31:0] iPREDICT_ADDR,
  output logic        oFLUSH_VALID,
  output logic [31:0] oFLUSH_ADDR,
  input  logic        iFLUSH_ACK,
  output logic        oPREDICT_UPDATE_VALID,
  output logic [31:0] oPREDICT_UPDATE_PC,
  output logic        oPREDICT_UPDATE_TAKEN,
  output logic [31:0] oPREDICT_UPDATE_ADDR,
  output logic        oIB_REQ,
  input  logic        iIB_ACK,
  output logic        oHALT,
  input  logic        iHALT_RELEASE
);

  typedef enum logic [1:0] {IDLE, FLUSH, IBREQ, HALTED} state_t;

  state_t      state_reg, state_next;
  logic [31:0] flush_addr_reg, flush_addr_next;
  logic        upd_valid_reg, upd_valid_next;
  logic [31:0] upd_pc_reg, upd_pc_next;
  logic        upd_taken_reg, upd_taken_next;
  logic [31:0] upd_addr_reg, upd_addr_next;

  logic        accept;
  logic        sel_halt, sel_ib, sel_idts, sel_br;
  logic        jump_miss, not_jump_miss, mispredict;
  logic [31:0] restart_addr;

  // Decode the accepted result with HALT > IB > IDTS > branch priority.
  always_comb begin
    accept        = iVALID && (state_reg == IDLE);
    sel_halt      = iHALT_VALID;
    sel_ib        = !iHALT_VALID && iIB_VALID;
    sel_idts      = !iHALT_VALID && !iIB_VALID && iIDTS_VALID;
    sel_br        = !iHALT_VALID && !iIB_VALID && !iIDTS_VALID &&
                    (iJUMP_VALID || iNOT_JUMP_VALID);
    // JUMP wins if both condition flags are set.
    jump_miss     = iJUMP_VALID && (!iPREDICT_TAKEN || (iPREDICT_ADDR != iBRANCH_ADDR));
    not_jump_miss = !iJUMP_VALID && iNOT_JUMP_VALID && iPREDICT_TAKEN;
    mispredict    = sel_br && (jump_miss || not_jump_miss);
    restart_addr  = (sel_idts || jump_miss) ? iBRANCH_ADDR : (iPC + 32'd4);
  end

  // Next-state logic and registered output contents.
  always_comb begin
    state_next      = state_reg;
    flush_addr_next = flush_addr_reg;
    upd_valid_next  = 1'b0;
    upd_pc_next     = upd_pc_reg;
    upd_taken_next  = upd_taken_reg;
    upd_addr_next   = upd_addr_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (sel_halt) begin
            state_next = HALTED;
          end else if (sel_ib) begin
            state_next = IBREQ;
          end else if (sel_idts || mispredict) begin
            state_next      = FLUSH;
            flush_addr_next = restart_addr;
          end
          if (sel_br) begin
            upd_valid_next = 1'b1;
            upd_pc_next    = iPC;
            upd_taken_next = iJUMP_VALID;
            upd_addr_next  = iBRANCH_ADDR;
          end
        end
      end
      FLUSH: begin
        if (iFLUSH_ACK) begin
          state_next      = IDLE;
          flush_addr_next = 32'd0;
        end
      end
      IBREQ: begin
        if (iIB_ACK) state_next = IDLE;
      end
      HALTED: begin
        if (iHALT_RELEASE) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset aborts any pending request.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_reg      <= IDLE;
      flush_addr_reg <= 32'd0;
      upd_valid_reg  <= 1'b0;
      upd_pc_reg     <= 32'd0;
      upd_taken_reg  <= 1'b0;
      upd_addr_reg   <= 32'd0;
    end else if (iRESET_SYNC) begin
      state_reg      <= IDLE;
      flush_addr_reg <= 32'd0;
      upd_valid_reg  <= 1'b0;
      upd_pc_reg     <= 32'd0;
      upd_taken_reg  <= 1'b0;
      upd_addr_reg   <= 32'd0;
    end else begin
      state_reg      <= state_next;
      flush_addr_reg <= flush_addr_next;
      upd_valid_reg  <= upd_valid_next;
      upd_pc_reg     <= upd_pc_next;
      upd_taken_reg  <= upd_taken_next;
      upd_addr_reg   <= upd_addr_next;
    end
  end

  assign oBUSY                 = (state_reg != IDLE);
  assign oFLUSH_VALID          = (state_reg == FLUSH);
  assign oFLUSH_ADDR           = flush_addr_reg;
  assign oIB_REQ               = (state_reg == IBREQ);
  assign oHALT                 = (state_reg == HALTED);
  assign oPREDICT_UPDATE_VALID = upd_valid_reg;
  assign oPREDICT_UPDATE_PC    = upd_pc_reg;
  assign oPREDICT_UPDATE_TAKEN = upd_taken_reg;
  assign oPREDICT_UPDATE_ADDR  = upd_addr_reg;

`ifdef EXECUTE_BRANCH_RESOLVE_STAT_EN
  logic [31:0] stat_branch_count_reg;
  logic [31:0] stat_miss_count_reg;

  // Saturating branch / mispredict counters.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      stat_branch_count_reg <= 32'd0;
      stat_miss_count_reg   <= 32'd0;
    end else if (iRESET_SYNC) begin
      stat_branch_count_reg <= 32'd0;
      stat_miss_count_reg   <= 32'd0;
    end else begin
      if (accept && sel_br && (stat_branch_count_reg != 32'hFFFF_FFFF))
        stat_branch_count_reg <= stat_branch_count_reg + 32'd1;
      if (accept && mispredict && (stat_miss_count_reg != 32'hFFFF_FFFF))
        stat_miss_count_reg <= stat_miss_count_reg + 32'd1;
    end
  end

  assign oSTAT_BRANCH_COUNT = stat_branch_count_reg;
  assign oSTAT_MISS_COUNT   = stat_miss_count_reg;
`endif

endmodule

// File: tb/tb_execute_branch_resolve.sv
// Self-checking bench for execute_branch_resolve: a behavioural model driven
// by the same inputs, a per-cycle compare process, and directed scenarios
// with literal expectations.
module tb_execute_branch_resolve;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iRESET_SYNC = 1'b0;
  logic        iVALID = 1'b0;
  logic        oBUSY;
  logic [31:0] iPC = '0;
  logic [31:0] iBRANCH_ADDR = '0;
  logic        iJUMP_VALID = 1'b0;
  logic        iNOT_JUMP_VALID = 1'b0;
  logic        iIB_VALID = 1'b0;
  logic        iIDTS_VALID = 1'b0;
  logic        iHALT_VALID = 1'b0;
  logic        iPREDICT_TAKEN = 1'b0;
  logic [31:0] iPREDICT_ADDR = '0;
  logic        oFLUSH_VALID;
  logic [31:0] oFLUSH_ADDR;
  logic        iFLUSH_ACK = 1'b0;
  logic        oPREDICT_UPDATE_VALID;
  logic [31:0] oPREDICT_UPDATE_PC;
  logic        oPREDICT_UPDATE_TAKEN;
  logic [31:0] oPREDICT_UPDATE_ADDR;
  logic        oIB_REQ;
  logic        iIB_ACK = 1'b0;
  logic        oHALT;
  logic        iHALT_RELEASE = 1'b0;
`ifdef EXECUTE_BRANCH_RESOLVE_STAT_EN
  logic [31:0] oSTAT_BRANCH_COUNT;
  logic [31:0] oSTAT_MISS_COUNT;
`endif

  execute_branch_resolve dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
`ifdef EXECUTE_BRANCH_RESOLVE_STAT_EN
    .oSTAT_BRANCH_COUNT(oSTAT_BRANCH_COUNT), .oSTAT_MISS_COUNT(oSTAT_MISS_COUNT),
`endif
    .iVALID(iVALID), .oBUSY(oBUSY), .iPC(iPC), .iBRANCH_ADDR(iBRANCH_ADDR),
    .iJUMP_VALID(iJUMP_VALID), .iNOT_JUMP_VALID(iNOT_JUMP_VALID),
    .iIB_VALID(iIB_VALID), .iIDTS_VALID(iIDTS_VALID), .iHALT_VALID(iHALT_VALID),
    .iPREDICT_TAKEN(iPREDICT_TAKEN), .iPREDICT_ADDR(iPREDICT_ADDR),
    .oFLUSH_VALID(oFLUSH_VALID), .oFLUSH_ADDR(oFLUSH_ADDR), .iFLUSH_ACK(iFLUSH_ACK),
    .oPREDICT_UPDATE_VALID(oPREDICT_UPDATE_VALID), .oPREDICT_UPDATE_PC(oPREDICT_UPDATE_PC),
    .oPREDICT_UPDATE_TAKEN(oPREDICT_UPDATE_TAKEN), .oPREDICT_UPDATE_ADDR(oPREDICT_UPDATE_ADDR),
    .oIB_REQ(oIB_REQ), .iIB_ACK(iIB_ACK), .oHALT(oHALT), .iHALT_RELEASE(iHALT_RELEASE)
  );

  always #5 iCLOCK = ~iCLOCK;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: which request is pending, and what was last resolved.
  bit          m_flush, m_ib, m_halt, m_upd, m_utaken;
  logic [31:0] m_faddr, m_upc, m_uaddr;

  initial begin
    {m_flush, m_ib, m_halt, m_upd, m_utaken} = '0;
    m_faddr = '0; m_upc = '0; m_uaddr = '0;
    forever begin
      @(posedge iCLOCK or negedge inRESET);
      if (!inRESET || iRESET_SYNC) begin
        {m_flush, m_ib, m_halt, m_upd, m_utaken} = '0;
        m_faddr = '0; m_upc = '0; m_uaddr = '0;
      end else begin
        m_upd = 1'b0;
        if (m_flush) begin
          if (iFLUSH_ACK) begin m_flush = 1'b0; m_faddr = '0; end
        end else if (m_ib) begin
          if (iIB_ACK) m_ib = 1'b0;
        end else if (m_halt) begin
          if (iHALT_RELEASE) m_halt = 1'b0;
        end else if (iVALID) begin
          if (iHALT_VALID) m_halt = 1'b1;
          else if (iIB_VALID) m_ib = 1'b1;
          else if (iIDTS_VALID) begin m_flush = 1'b1; m_faddr = iBRANCH_ADDR; end
          else if (iJUMP_VALID || iNOT_JUMP_VALID) begin
            m_upd = 1'b1; m_upc = iPC; m_utaken = iJUMP_VALID; m_uaddr = iBRANCH_ADDR;
            if (iJUMP_VALID && (!iPREDICT_TAKEN || iPREDICT_ADDR != iBRANCH_ADDR)) begin
              m_flush = 1'b1; m_faddr = iBRANCH_ADDR;
            end else if (!iJUMP_VALID && iPREDICT_TAKEN) begin
              m_flush = 1'b1; m_faddr = iPC + 32'd4;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge iCLOCK);
    if (check_en) begin
      chk("cmp_busy", {31'd0, oBUSY}, {31'd0, m_flush | m_ib | m_halt});
      chk("cmp_flush", {31'd0, oFLUSH_VALID}, {31'd0, m_flush});
      chk("cmp_flush_addr", oFLUSH_ADDR, m_faddr);
      chk("cmp_ib", {31'd0, oIB_REQ}, {31'd0, m_ib});
      chk("cmp_halt", {31'd0, oHALT}, {31'd0, m_halt});
      chk("cmp_upd", {31'd0, oPREDICT_UPDATE_VALID}, {31'd0, m_upd});
      if (m_upd) begin
        chk("cmp_upd_pc", oPREDICT_UPDATE_PC, m_upc);
        chk("cmp_upd_taken", {31'd0, oPREDICT_UPDATE_TAKEN}, {31'd0, m_utaken});
        chk("cmp_upd_addr", oPREDICT_UPDATE_ADDR, m_uaddr);
      end
    end
  end

  task automatic tick;
    @(posedge iCLOCK); #1;
  endtask

  task automatic drive(input logic j, nj, ib, idts, halt, input logic [31:0] pc, ba,
                       input logic pt, input logic [31:0] pa);
    iVALID = 1'b1; iJUMP_VALID = j; iNOT_JUMP_VALID = nj; iIB_VALID = ib;
    iIDTS_VALID = idts; iHALT_VALID = halt; iPC = pc; iBRANCH_ADDR = ba;
    iPREDICT_TAKEN = pt; iPREDICT_ADDR = pa;
  endtask

  task automatic idle_in;
    iVALID = 1'b0; iJUMP_VALID = 1'b0; iNOT_JUMP_VALID = 1'b0; iIB_VALID = 1'b0;
    iIDTS_VALID = 1'b0; iHALT_VALID = 1'b0;
  endtask

  // One accepted result; returns #1 into the following cycle.
  task automatic send(input logic j, nj, ib, idts, halt, input logic [31:0] pc, ba,
                      input logic pt, input logic [31:0] pa);
    drive(j, nj, ib, idts, halt, pc, ba, pt, pa);
    tick;
    idle_in;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick;
    @(negedge iCLOCK);
    chk("rst_flush", {31'd0, oFLUSH_VALID}, 32'd0);
    chk("rst_flush_addr", oFLUSH_ADDR, 32'd0);
    chk("rst_upd", {31'd0, oPREDICT_UPDATE_VALID}, 32'd0);
    chk("rst_upd_pc", oPREDICT_UPDATE_PC, 32'd0);
    chk("rst_upd_addr", oPREDICT_UPDATE_ADDR, 32'd0);
    chk("rst_busy", {31'd0, oBUSY}, 32'd0);
    chk("rst_ib_halt", {30'd0, oIB_REQ, oHALT}, 32'd0);
    inRESET = 1'b1;
    check_en = 1'b1;
    tick;

    // Correctly predicted taken branch.
    send(1, 0, 0, 0, 0, 32'h100, 32'h200, 1, 32'h200);
    @(negedge iCLOCK);
    chk("t1_upd", {31'd0, oPREDICT_UPDATE_VALID}, 32'd1);
    chk("t1_upd_pc", oPREDICT_UPDATE_PC, 32'h100);
    chk("t1_upd_taken", {31'd0, oPREDICT_UPDATE_TAKEN}, 32'd1);
    chk("t1_upd_addr", oPREDICT_UPDATE_ADDR, 32'h200);
    chk("t1_busy", {31'd0, oBUSY}, 32'd0);
    tick;
    @(negedge iCLOCK);
    chk("t1_upd_pulse", {31'd0, oPREDICT_UPDATE_VALID}, 32'd0);

    // Taken branch predicted not-taken; ack in the accept cycle is ignored.
    iFLUSH_ACK = 1'b1;
    send(1, 0, 0, 0, 0, 32'h100, 32'h200, 0, 32'h200);
    iFLUSH_ACK = 1'b0;
    @(negedge iCLOCK);
    chk("t2_flush", {31'd0, oFLUSH_VALID}, 32'd1);
    chk("t2_flush_addr", oFLUSH_ADDR, 32'h200);
    chk("t2_busy", {31'd0, oBUSY}, 32'd1);
    tick;
    tick;
    iFLUSH_ACK = 1'b1;
    drive(1, 0, 0, 0, 0, 32'h300, 32'h400, 1, 32'h400);
    @(negedge iCLOCK);
    chk("t2_flush_c3", {31'd0, oFLUSH_VALID}, 32'd1);
    tick;
    iFLUSH_ACK = 1'b0;
    @(negedge iCLOCK);
    chk("t2_flush_drop", {31'd0, oFLUSH_VALID}, 32'd0);
    chk("t2_busy_drop", {31'd0, oBUSY}, 32'd0);
    chk("t2_no_upd_busy", {31'd0, oPREDICT_UPDATE_VALID}, 32'd0);
    tick;
    idle_in;
    @(negedge iCLOCK);
    chk("t2_next_accept", oPREDICT_UPDATE_PC, 32'h300);

    // Not-taken branch predicted taken at the top of the address space.
    send(0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h5678, 1, 32'h1234);
    @(negedge iCLOCK);
    chk("t3_flush_addr", oFLUSH_ADDR, 32'h0);
    chk("t3_flush", {31'd0, oFLUSH_VALID}, 32'd1);
    chk("t3_upd_taken", {31'd0, oPREDICT_UPDATE_TAKEN}, 32'd0);
    iFLUSH_ACK = 1'b1;
    tick;
    iFLUSH_ACK = 1'b0;

    // IB outranks a mispredicted jump; wrong acks do not release it.
    send(1, 0, 1, 0, 0, 32'h500, 32'h600, 0, 32'h0);
    @(negedge iCLOCK);
    chk("t4_ib", {31'd0, oIB_REQ}, 32'd1);
    chk("t4_no_flush", {31'd0, oFLUSH_VALID}, 32'd0);
    chk("t4_no_upd", {31'd0, oPREDICT_UPDATE_VALID}, 32'd0);
    iFLUSH_ACK = 1'b1; iHALT_RELEASE = 1'b1;
    tick;
    iFLUSH_ACK = 1'b0; iHALT_RELEASE = 1'b0;
    @(negedge iCLOCK);
    chk("t4_ib_held", {31'd0, oIB_REQ}, 32'd1);
    iIB_ACK = 1'b1;
    tick;
    iIB_ACK = 1'b0;
    @(negedge iCLOCK);
    chk("t4_ib_done", {31'd0, oBUSY}, 32'd0);

    // HALT outranks IDTS; release while idle beforehand is ignored.
    iHALT_RELEASE = 1'b1;
    tick;
    iHALT_RELEASE = 1'b0;
    send(0, 0, 0, 1, 1, 32'h700, 32'h800, 0, 32'h0);
    repeat (2) tick;
    @(negedge iCLOCK);
    chk("t4_halt", {31'd0, oHALT}, 32'd1);
    chk("t4_halt_noflush", {31'd0, oFLUSH_VALID}, 32'd0);
    iHALT_RELEASE = 1'b1;
    tick;
    iHALT_RELEASE = 1'b0;
    @(negedge iCLOCK);
    chk("t4_halt_done", {31'd0, oHALT}, 32'd0);

    // IDTS flushes unconditionally with no predictor update.
    send(1, 0, 0, 1, 0, 32'h40, 32'h900, 1, 32'h900);
    @(negedge iCLOCK);
    chk("idts_addr", oFLUSH_ADDR, 32'h900);
    chk("idts_no_upd", {31'd0, oPREDICT_UPDATE_VALID}, 32'd0);
    iFLUSH_ACK = 1'b1;
    tick;
    iFLUSH_ACK = 1'b0;

    // Valid with no indication is consumed silently.
    send(0, 0, 0, 0, 0, 32'h44, 32'h48, 1, 32'h0);
    @(negedge iCLOCK);
    chk("empty_busy", {31'd0, oBUSY}, 32'd0);

    // Async reset while a flush and update are pending.
    send(1, 0, 0, 0, 0, 32'hA00, 32'hABC, 0, 32'h0);
    @(negedge iCLOCK);
    chk("t5_pre_flush", {31'd0, oFLUSH_VALID}, 32'd1);
    #2 inRESET = 1'b0;
    #1;
    chk("t5_flush", {31'd0, oFLUSH_VALID}, 32'd0);
    chk("t5_flush_addr", oFLUSH_ADDR, 32'd0);
    chk("t5_upd", {31'd0, oPREDICT_UPDATE_VALID}, 32'd0);
    chk("t5_upd_pc", oPREDICT_UPDATE_PC, 32'd0);
    chk("t5_busy", {31'd0, oBUSY}, 32'd0);
    tick;
    inRESET = 1'b1;
    @(negedge iCLOCK);
    chk("t5_idle", {31'd0, oBUSY}, 32'd0);

    // Synchronous clear aborts a pending IB request.
    send(0, 0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    iRESET_SYNC = 1'b1;
    tick;
    iRESET_SYNC = 1'b0;
    @(negedge iCLOCK);
    chk("sync_clear", {31'd0, oIB_REQ}, 32'd0);

    // Sweep of prediction combinations, each followed by one ack cycle.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] s;
      s = 3'(i);
      send(s[0], !s[0], 0, 0, 0, 32'h1000 + 32'(i * 4), 32'h200, s[1],
           s[2] ? 32'h200 : 32'h204);
      iFLUSH_ACK = 1'b1;
      tick;
      iFLUSH_ACK = 1'b0;
    end

`ifdef EXECUTE_BRANCH_RESOLVE_STAT_EN
    iRESET_SYNC = 1'b1;
    tick;
    iRESET_SYNC = 1'b0;
    send(1, 0, 0, 0, 0, 32'h10, 32'h20, 1, 32'h20);
    send(0, 1, 0, 0, 0, 32'h14, 32'h20, 0, 32'h0);
    send(1, 0, 0, 0, 0, 32'h18, 32'h20, 0, 32'h0);
    iFLUSH_ACK = 1'b1; tick; iFLUSH_ACK = 1'b0;
    send(0, 1, 0, 0, 0, 32'h1C, 32'h20, 1, 32'h20);
    iFLUSH_ACK = 1'b1; tick; iFLUSH_ACK = 1'b0;
    send(1, 0, 0, 0, 0, 32'h24, 32'h30, 1, 32'h30);
    @(negedge iCLOCK);
    chk("stat_branch", oSTAT_BRANCH_COUNT, 32'd5);
    chk("stat_miss", oSTAT_MISS_COUNT, 32'd2);
    force dut.stat_branch_count_reg = 32'hFFFF_FFFF;
    #1 release dut.stat_branch_count_reg;
    send(1, 0, 0, 0, 0, 32'h28, 32'h30, 1, 32'h30);
    @(negedge iCLOCK);
    chk("stat_saturate", oSTAT_BRANCH_COUNT, 32'hFFFF_FFFF);
    chk("stat_miss_hold", oSTAT_MISS_COUNT, 32'd2);
`endif

    tick;
    @(negedge iCLOCK);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
